// File: rtl/behavioral_light_occupancy_ctrl.sv
// Room-light controller: debounced light/occupancy sensors, hold-after-vacancy timer,
// manual on/off override and a post-manual-off lockout window.
module behavioral_light_occupancy_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in1,
  input  logic       in2,
  input  logic       man_on,
  input  logic       man_off,
  output logic       out1,
  output logic [2:0] state,
  output logic       hold_active
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DCW-1:0] DebLast  = DCW'(DEB_CYCLES - 1);
  localparam logic [HCW-1:0] HoldLoad = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StOff     = 3'd0,
    StOn      = 3'd1,
    StHold    = 3'd2,
    StManual  = 3'd3,
    StLockout = 3'd4
  } state_e;

  // Bit 0 carries the light sensor, bit 1 the occupancy sensor.
  logic [1:0]     s1_q, s2_q, deb_q;
  logic [DCW-1:0] deb_cnt_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      deb_q        <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
    end else begin
      s1_q <= {in2, in1};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == DebLast) begin
            deb_q[i]     <= s2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DCW'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic light_d, pres_d;
  assign light_d = deb_q[0];
  assign pres_d  = deb_q[1];

  state_e         state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           out1_q, out1_d, hold_active_q, hold_active_d;
  logic           man_on_only, man_off_only;

  // A simultaneous on/off pair cancels out; the sensor rules then decide.
  assign man_on_only  = man_on & ~man_off;
  assign man_off_only = man_off & ~man_on;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (man_on_only) begin
      state_d = StManual;
    end else if (man_off_only && (state_q == StOn || state_q == StHold)) begin
      state_d    = StLockout;
      hold_cnt_d = HoldLoad;
    end else if (man_off_only && state_q == StManual) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff: if (!light_d && pres_d) state_d = StOn;
        StOn: begin
          if (light_d) begin
            state_d = StOff;
          end else if (!pres_d) begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
          end
        end
        StHold: begin
          if (light_d) state_d = StOff;
          else if (pres_d) state_d = StOn;
          else if (hold_cnt_q == '0) state_d = StOff;
          else hold_cnt_d = hold_cnt_q - HCW'(1);
        end
        StManual: ;
        StLockout: begin
          if (pres_d) hold_cnt_d = HoldLoad;
          else if (hold_cnt_q == '0) state_d = StOff;
          else hold_cnt_d = hold_cnt_q - HCW'(1);
        end
        default: state_d = StOff;
      endcase
    end
    if (state_d != StHold && state_d != StLockout) hold_cnt_d = '0;
    out1_d        = (state_d == StOn) || (state_d == StHold) || (state_d == StManual);
    hold_active_d = (state_d == StHold) || (state_d == StLockout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StOff;
      hold_cnt_q    <= '0;
      out1_q        <= 1'b0;
      hold_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      out1_q        <= out1_d;
      hold_active_q <= hold_active_d;
    end
  end

  assign out1        = out1_q;
  assign state       = state_q;
  assign hold_active = hold_active_q;

endmodule

// File: tb/tb_behavioral_light_occupancy_ctrl.sv
// Directed bench for behavioral_light_occupancy_ctrl with DEB_CYCLES=4, HOLD_CYCLES=8.
module tb_behavioral_light_occupancy_ctrl;

  logic       clk = 1'b0;
  logic       rst, in1, in2, man_on, man_off;
  logic       out1, hold_active;
  logic [2:0] state;
  int         n_tests = 0;
  int         n_fail  = 0;

  behavioral_light_occupancy_ctrl #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in2        (in2),
    .man_on     (man_on),
    .man_off    (man_off),
    .out1       (out1),
    .state      (state),
    .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input int st, input int o, input int h);
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".out1"}, 32'(out1), 32'(o));
    check_eq({tag, ".hold"}, 32'(hold_active), 32'(h));
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in1 = 1'b0; in2 = 1'b0; man_on = 1'b0; man_off = 1'b0;
    step(2);
    check_st("reset", 0, 0, 0);
    rst = 1'b0;
    step(1);

    // Auto on: out1 rises on the 7th edge after in2 rises.
    in2 = 1'b1;
    step(6);
    check_st("auto_on_e6", 0, 0, 0);
    step(1);
    check_st("auto_on_e7", 1, 1, 0);
    // Vacancy: HOLD entered on 7th edge, out1 held for 8 edges.
    in2 = 1'b0;
    step(6);
    check_st("vac_e6", 1, 1, 0);
    step(1);
    check_st("hold_entry", 2, 1, 1);
    step(7);
    check_st("hold_last", 2, 1, 1);
    step(1);
    check_st("hold_done", 0, 0, 0);

    // Glitch of 3 cycles is rejected.
    in2 = 1'b1;
    step(3);
    in2 = 1'b0;
    step(20);
    check_st("glitch", 0, 0, 0);

    // Re-trigger during HOLD, then daylight.
    in2 = 1'b1;
    step(7);
    check_st("rt_on", 1, 1, 0);
    in2 = 1'b0;
    step(7);
    check_st("rt_hold", 2, 1, 1);
    in2 = 1'b1;
    step(6);
    check_st("rt_still_hold", 2, 1, 1);
    step(1);
    check_st("rt_back_on", 1, 1, 0);
    in1 = 1'b1;
    step(6);
    check_st("day_e6", 1, 1, 0);
    step(1);
    check_st("day_off", 0, 0, 0);

    // Manual override with daylight and occupancy.
    man_on = 1'b1;
    step(1);
    man_on = 1'b0;
    check_st("man_on", 3, 1, 0);
    step(10);
    check_st("man_hold", 3, 1, 0);
    man_on = 1'b1; man_off = 1'b1;
    step(1);
    man_on = 1'b0; man_off = 1'b0;
    check_st("man_both", 3, 1, 0);
    man_off = 1'b1;
    step(1);
    man_off = 1'b0;
    check_st("man_off", 0, 0, 0);
    man_on = 1'b1; man_off = 1'b1;
    step(1);
    man_on = 1'b0; man_off = 1'b0;
    check_st("both_in_off", 0, 0, 0);

    // Lockout.
    in1 = 1'b0;
    step(7);
    check_st("lk_on", 1, 1, 0);
    man_off = 1'b1;
    step(1);
    man_off = 1'b0;
    check_st("lk_enter", 4, 0, 1);
    step(10);
    check_st("lk_occupied", 4, 0, 1);
    in2 = 1'b0;
    step(13);
    check_st("lk_last", 4, 0, 1);
    step(1);
    check_st("lk_exit", 0, 0, 0);
    in2 = 1'b1;
    step(6);
    check_st("post_lk_e6", 0, 0, 0);
    step(1);
    check_st("post_lk_on", 1, 1, 0);

    // Reset mid-HOLD with conflicting inputs.
    in2 = 1'b0;
    step(9);
    check_st("pre_rst_hold", 2, 1, 1);
    rst = 1'b1; man_on = 1'b1; in1 = 1'b0; in2 = 1'b1;
    step(1);
    check_st("rst_edge", 0, 0, 0);
    step(12);
    check_st("rst_held", 0, 0, 0);
    rst = 1'b0; man_on = 1'b0; in2 = 1'b0;
    step(10);
    check_st("post_rst", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
